// File: rtl/pipe_rca_pkg.sv
// pipe_rca_pkg: shared defaults for the pipelined ripple-carry adder.
package pipe_rca_pkg;

    localparam int unsigned BW_DEF     = 32;
    localparam int unsigned STAGES_DEF = 4;
    localparam int unsigned CW_DEF     = BW_DEF / STAGES_DEF;

endpackage

// File: rtl/rca_chunk.sv
// rca_chunk: combinational CW-bit ripple-carry adder made of a chain of full-adder cells.
module rca_chunk
    import pipe_rca_pkg::*;
#(
    parameter int unsigned CW = CW_DEF
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          ci,
    output logic [CW-1:0] s,
    output logic          co
);

    // One full adder per bit; each cell keeps its own carry so the chain is explicit.
    for (genvar i = 0; i < CW; i++) begin : g_bit
        logic c_in;
        logic c_out;

        if (i == 0) begin : g_lsb
            assign c_in = ci;
        end else begin : g_upper
            assign c_in = g_bit[i-1].c_out;
        end

        assign s[i]  = a[i] ^ b[i] ^ c_in;
        assign c_out = (a[i] & b[i]) | (c_in & (a[i] ^ b[i]));
    end

    assign co = g_bit[CW-1].c_out;

endmodule

// File: rtl/pipe_ripple_carry_adder.sv
// pipe_ripple_carry_adder: fully pipelined BW-bit adder, one CW-bit chunk per stage.
// Latency is STAGES cycles after the input register; one operand set accepted per clock.
// Optional macro PIPE_RCA_VALID_EN adds in_valid/out_valid tracked alongside the data.
module pipe_ripple_carry_adder
    import pipe_rca_pkg::*;
#(
    parameter int unsigned BW     = BW_DEF,
    parameter int unsigned STAGES = STAGES_DEF
) (
    input  logic          CLK,
    input  logic          RESETn,
    input  logic [BW:1]   A,
    input  logic [BW:1]   B,
    input  logic          cin,
`ifdef PIPE_RCA_VALID_EN
    input  logic          in_valid,
    output logic          out_valid,
`endif
    output logic [BW:1]   sum,
    output logic          cout
);

    localparam int unsigned CW = BW / STAGES;

    logic              cin_q;
    // carry[0] is the registered cin; carry[j+1] is the registered carry out of chunk j.
    logic [STAGES:0]   carry;

    // Input register for the carry-in (level 0 of the pipe).
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            cin_q <= 1'b0;
        end else begin
            cin_q <= cin;
        end
    end

    assign carry[0] = cin_q;

    for (genvar j = 0; j < STAGES; j++) begin : g_chunk
        // Operand chunk j is captured at level 0 and skewed until stage j+1 consumes it.
        logic [CW-1:0] a_q [j+1];
        logic [CW-1:0] b_q [j+1];
        // Chunk j's sum is produced at level j+1 and de-skewed to level STAGES.
        logic [CW-1:0] s_q [STAGES-j];
        logic [CW-1:0] s_c;
        logic          co_c;
        logic          co_q;

        rca_chunk #(
            .CW (CW)
        ) u_chunk (
            .a  (a_q[j]),
            .b  (b_q[j]),
            .ci (carry[j]),
            .s  (s_c),
            .co (co_c)
        );

        // Operand skew, chunk sum/carry capture and sum de-skew for this chunk.
        always_ff @(posedge CLK or negedge RESETn) begin
            if (!RESETn) begin
                for (int i = 0; i <= j; i++) begin
                    a_q[i] <= '0;
                    b_q[i] <= '0;
                end
                for (int i = 0; i < STAGES - j; i++) begin
                    s_q[i] <= '0;
                end
                co_q <= 1'b0;
            end else begin
                a_q[0] <= A[j*CW+1 +: CW];
                b_q[0] <= B[j*CW+1 +: CW];
                for (int i = 1; i <= j; i++) begin
                    a_q[i] <= a_q[i-1];
                    b_q[i] <= b_q[i-1];
                end
                s_q[0] <= s_c;
                for (int i = 1; i < STAGES - j; i++) begin
                    s_q[i] <= s_q[i-1];
                end
                co_q <= co_c;
            end
        end

        assign carry[j+1]         = co_q;
        assign sum[j*CW+1 +: CW] = s_q[STAGES-1-j];
    end

    assign cout = carry[STAGES];

`ifdef PIPE_RCA_VALID_EN
    logic [STAGES:0] vld_q;

    // Valid flag rides a STAGES+1 deep shift register aligned with the data path.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[STAGES-1:0], in_valid};
        end
    end

    assign out_valid = vld_q[STAGES];
`endif

endmodule

// File: tb/tb_pipe_ripple_carry_adder.sv
// tb_pipe_ripple_carry_adder: randomized and directed checks against an arithmetic model.
module tb_pipe_ripple_carry_adder;

    localparam int unsigned BW     = 32;
    localparam int unsigned STAGES = 4;

    logic          CLK = 1'b0;
    logic          RESETn;
    logic [BW:1]   A;
    logic [BW:1]   B;
    logic          cin;
    logic [BW:1]   sum;
    logic          cout;
`ifdef PIPE_RCA_VALID_EN
    logic          in_valid;
    logic          out_valid;
    bit            vld_pat [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    bit            vld_exp_q [$];
`endif

    int unsigned   n_checks = 0;
    int unsigned   n_fail   = 0;

    // Expected {cout, sum} per edge; front entry is what the outputs should show now.
    logic [BW:0]   exp_q [$];

    always #5 CLK = ~CLK;

    pipe_ripple_carry_adder #(
        .BW     (BW),
        .STAGES (STAGES)
    ) dut (
        .CLK       (CLK),
        .RESETn    (RESETn),
        .A         (A),
        .B         (B),
        .cin       (cin),
`ifdef PIPE_RCA_VALID_EN
        .in_valid  (in_valid),
        .out_valid (out_valid),
`endif
        .sum       (sum),
        .cout      (cout)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        repeat (STAGES + 1) exp_q.push_back('0);
`ifdef PIPE_RCA_VALID_EN
        vld_exp_q.delete();
        repeat (STAGES + 1) vld_exp_q.push_back(1'b0);
`endif
    endtask

    task automatic drive(input logic [BW:1] a, input logic [BW:1] b, input logic c);
        A   = a;
        B   = b;
        cin = c;
`ifdef PIPE_RCA_VALID_EN
        in_valid = 1'($urandom());
`endif
    endtask

    task automatic drive_rand();
        drive($urandom(), $urandom(), 1'($urandom()));
    endtask

    // Advance one edge, update the model with what was captured, then compare.
    task automatic tick();
        logic [BW:0] e;
        @(posedge CLK);
        if (RESETn) exp_q.push_back({1'b0, A} + {1'b0, B} + {{BW{1'b0}}, cin});
        else        exp_q.push_back('0);
        void'(exp_q.pop_front());
`ifdef PIPE_RCA_VALID_EN
        vld_exp_q.push_back(RESETn ? bit'(in_valid) : 1'b0);
        void'(vld_exp_q.pop_front());
`endif
        #1;
        e = exp_q[0];
        check_eq("model_sum", 64'(sum), 64'(e[BW-1:0]));
        check_eq("model_cout", 64'(cout), 64'(e[BW]));
`ifdef PIPE_RCA_VALID_EN
        check_eq("model_valid", 64'(out_valid), 64'(vld_exp_q[0]));
`endif
    endtask

    // Apply one vector, push random filler behind it and check the result STAGES edges on.
    task automatic directed(input string tag, input logic [BW:1] a, input logic [BW:1] b,
                            input logic c, input logic [BW:1] es, input logic ec);
        drive(a, b, c);
        tick();
        repeat (STAGES) begin
            drive_rand();
            tick();
        end
        check_eq({tag, "_sum"}, 64'(sum), 64'(es));
        check_eq({tag, "_cout"}, 64'(cout), 64'(ec));
    endtask

    // A += 30000, B += 50000 per cycle starting from index n0.
    task automatic stream(input longint unsigned n0, input int count);
        longint unsigned n;
        longint unsigned tot;
        for (int i = 0; i < count; i++) begin
            n = n0 + longint'(i);
            drive(32'(30000 * n), 32'(50000 * n), 1'b0);
            tick();
            if (i >= int'(STAGES)) begin
                tot = 80000 * (n - STAGES);
                check_eq("stream_sum", 64'(sum), tot & 64'hFFFF_FFFF);
                check_eq("stream_cout", 64'(cout), 64'(tot >= 64'h1_0000_0000));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESETn = 1'b1;
        drive_rand();
        model_clear();
        #1 RESETn = 1'b0;
        #1;
        check_eq("rst_async_sum", 64'(sum), 64'h0);
        check_eq("rst_async_cout", 64'(cout), 64'h0);
        repeat (2) tick();

        @(negedge CLK);
        RESETn = 1'b1;
        drive('0, '0, 1'b0);
        repeat (STAGES) begin
            tick();
            check_eq("post_rst_sum", 64'(sum), 64'h0);
            check_eq("post_rst_cout", 64'(cout), 64'h0);
        end

        directed("chunk_carry", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0);
        directed("wrap_cin",    32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1);
        directed("max",         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);
        directed("cin_only",    32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0);
        directed("mid_carry",   32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0);

        repeat (200) begin
            drive_rand();
            tick();
        end

        // Asynchronous reset in the middle of a random stream.
        #2 RESETn = 1'b0;
        #1;
        check_eq("rst_mid_sum", 64'(sum), 64'h0);
        check_eq("rst_mid_cout", 64'(cout), 64'h0);
        model_clear();
        tick();
        @(negedge CLK);
        RESETn = 1'b1;
        repeat (STAGES) begin
            drive_rand();
            tick();
            check_eq("rst_flush_sum", 64'(sum), 64'h0);
            check_eq("rst_flush_cout", 64'(cout), 64'h0);
        end
        repeat (20) begin
            drive_rand();
            tick();
        end

        stream(0, 100);
        stream(53670, 40);

`ifdef PIPE_RCA_VALID_EN
        for (int i = 0; i < 8; i++) begin
            drive_rand();
            in_valid = vld_pat[i];
            tick();
            if (i >= int'(STAGES)) check_eq("valid_pat", 64'(out_valid), 64'(vld_pat[i-STAGES]));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
